// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : display_scheduler
// Purpose  : Round-robin arbitration of three sources for a 4-digit display,
//            with a double-dabble binary-to-BCD converter on the granted value.
// Revision : 1.0 - initial release
// ============================================================================
module display_scheduler #(
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter int unsigned SAT_MAX     = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  src_req,
    input  logic [47:0] src_value,
    output logic [2:0]  src_grant,
    output logic [15:0] disp_bcd,
    output logic        disp_valid,
    output logic        disp_ovf
);

    localparam logic [15:0] C_SAT_MAX = 16'(SAT_MAX);
    localparam logic [31:0] C_HOLD    = 32'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // First requester strictly after 'from', wrapping, ending at 'from' itself.
    function automatic logic [2:0] pick(input logic [1:0] from, input logic [2:0] req);
        logic [1:0] j;
        logic       found;
        pick  = 3'b000;
        found = 1'b0;
        j     = from;
        for (int k = 0; k < 3; k++) begin
            j = (j == 2'd2) ? 2'd0 : j + 2'd1;
            if (!found && req[j]) begin
                pick[j] = 1'b1;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [1:0] idx(input logic [2:0] oh);
        idx = oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
    endfunction

    logic [2:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] hold_q, hold_d;
    logic [2:0]  w_first, w_others;

    always_comb begin
        grant_d  = grant_q;
        last_d   = last_q;
        hold_d   = hold_q;
        w_first  = pick(last_q, src_req);
        w_others = pick(idx(grant_q), src_req & ~grant_q);
        if (grant_q == 3'b000) begin
            if (w_first != 3'b000) begin
                grant_d = w_first;
                last_d  = idx(w_first);
                hold_d  = 32'd0;
            end
        end else if ((src_req & grant_q) == 3'b000) begin
            // A dropped request wins over hold expiry.
            grant_d = w_others;
            if (w_others != 3'b000) begin
                last_d = idx(w_others);
            end
            hold_d = 32'd0;
        end else if (hold_q >= C_HOLD) begin
            hold_d = 32'd0;
            if (w_others != 3'b000) begin
                grant_d = w_others;
                last_d  = idx(w_others);
            end
        end else begin
            hold_d = hold_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q <= 3'b000;
            last_q  <= 2'd2;
            hold_q  <= 32'd0;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Converter: work register holds {bcd[15:0], binary[15:0]}.
    conv_state_t state_q;
    logic [3:0]  iter_q;
    logic [31:0] work_q, dabble_d;
    logic        ovf_q;
    logic [15:0] disp_bcd_q;
    logic        disp_valid_q, disp_ovf_q;
    logic [15:0] w_value, w_sat, w_bcd;

    always_comb begin
        case (grant_q)
            3'b010:  w_value = src_value[31:16];
            3'b100:  w_value = src_value[47:32];
            default: w_value = src_value[15:0];
        endcase
        w_sat = (w_value > C_SAT_MAX) ? C_SAT_MAX : w_value;
        w_bcd = work_q[31:16];
        for (int n = 0; n < 4; n++) begin
            if (w_bcd[4*n +: 4] >= 4'd5) begin
                w_bcd[4*n +: 4] = w_bcd[4*n +: 4] + 4'd3;
            end
        end
        dabble_d = {w_bcd[14:0], work_q[15:0], 1'b0};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            iter_q       <= 4'd0;
            work_q       <= 32'd0;
            ovf_q        <= 1'b0;
            disp_bcd_q   <= 16'h0000;
            disp_valid_q <= 1'b0;
            disp_ovf_q   <= 1'b0;
        end else begin
            disp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_q != 3'b000) begin
                        work_q  <= {16'h0000, w_sat};
                        ovf_q   <= (w_value > C_SAT_MAX);
                        iter_q  <= 4'd0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= dabble_d;
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == 4'd15) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    disp_bcd_q   <= work_q[31:16];
                    disp_ovf_q   <= ovf_q;
                    disp_valid_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign src_grant  = grant_q;
    assign disp_bcd   = disp_bcd_q;
    assign disp_valid = disp_valid_q;
    assign disp_ovf   = disp_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scheduler
// Purpose  : Directed and random checks of display_scheduler against a
//            cycle-level behavioural model (HOLD_CYCLES = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scheduler;

    localparam int HOLD = 8;
    localparam int SAT  = 9999;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  src_req = 3'b000;
    logic [47:0] src_value = 48'd0;
    logic [2:0]  src_grant;
    logic [15:0] disp_bcd;
    logic        disp_valid;
    logic        disp_ovf;

    int total = 0;
    int bad   = 0;

    display_scheduler #(.HOLD_CYCLES(HOLD), .SAT_MAX(SAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_req    (src_req),
        .src_value  (src_value),
        .src_grant  (src_grant),
        .disp_bcd   (disp_bcd),
        .disp_valid (disp_valid),
        .disp_ovf   (disp_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: holder index (-1 = none), dwell count, conversion timer.
    int          m_g, m_last, m_hold, m_cnt, m_cval;
    bit          m_busy, m_covf, m_ovf, m_valid;
    logic [15:0] m_bcd;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int next_req(input int from, input int excl);
        for (int k = 1; k <= 3; k++) begin
            int s;
            s = (from + k) % 3;
            if (src_req[s] && s != excl) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_g = -1; m_last = 2; m_hold = 0; m_cnt = 0; m_cval = 0;
        m_busy = 0; m_covf = 0; m_ovf = 0; m_valid = 0; m_bcd = 16'h0000;
    endtask

    task automatic model_update();
        int n, v;
        m_valid = 0;
        if (!m_busy) begin
            if (m_g >= 0) begin
                v      = int'(src_value[16*m_g +: 16]);
                m_covf = (v > SAT);
                m_cval = m_covf ? SAT : v;
                m_busy = 1;
                m_cnt  = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 17) begin
                m_bcd   = to_bcd(m_cval);
                m_ovf   = m_covf;
                m_valid = 1;
                m_busy  = 0;
            end
        end
        if (m_g < 0) begin
            n = next_req(m_last, -1);
            if (n >= 0) begin m_g = n; m_last = n; m_hold = 0; end
        end else if (!src_req[m_g]) begin
            n = next_req(m_g, m_g);
            m_g = n;
            if (n >= 0) m_last = n;
            m_hold = 0;
        end else if (m_hold >= HOLD) begin
            n = next_req(m_g, m_g);
            if (n >= 0) begin m_g = n; m_last = n; end
            m_hold = 0;
        end else begin
            m_hold++;
        end
    endtask

    task automatic check_all();
        logic [2:0] eg;
        eg = (m_g < 0) ? 3'b000 : (3'b001 << m_g);
        total += 4;
        assert (src_grant === eg) else begin bad++; $error("FAIL grant obs=%b exp=%b", src_grant, eg); end
        assert (disp_valid === m_valid) else begin bad++; $error("FAIL valid obs=%b exp=%b", disp_valid, m_valid); end
        assert (disp_bcd === m_bcd) else begin bad++; $error("FAIL bcd obs=%h exp=%h", disp_bcd, m_bcd); end
        assert (disp_ovf === m_ovf) else begin bad++; $error("FAIL ovf obs=%b exp=%b", disp_ovf, m_ovf); end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Assert reset away from the clock edge, hold it, release mid-cycle.
    task automatic do_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        reset = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            waited++;
            if (disp_valid === 1'b1) ok = 1;
        end
        total++;
        assert (ok) else begin bad++; $error("FAIL valid_timeout obs=0 exp=1 budget=%0d", budget); end
    endtask

    task automatic expect_disp(input string tag, input logic [15:0] bcd, input logic ovf);
        total += 2;
        assert (disp_bcd === bcd) else begin bad++; $error("FAIL %s bcd obs=%h exp=%h", tag, disp_bcd, bcd); end
        assert (disp_ovf === ovf) else begin bad++; $error("FAIL %s ovf obs=%b exp=%b", tag, disp_ovf, ovf); end
    endtask

    task automatic expect_grant(input string tag, input logic [2:0] g);
        total++;
        assert (src_grant === g) else begin bad++; $error("FAIL %s obs=%b exp=%b", tag, src_grant, g); end
    endtask

    initial begin
        int w;
        @(posedge clk);
        #1;
        do_reset(3);

        // All sources requesting: 0 first, then rotation 1, 2, 0.
        src_req = 3'b111;
        src_value = {16'd300, 16'd20, 16'd1};
        tick();
        expect_grant("rr_first", 3'b001);
        for (int i = 0; i < 60; i++) tick();

        // Single source, value 1234, repeating every 18 cycles.
        do_reset(2);
        src_req = 3'b001;
        src_value = {16'd0, 16'd0, 16'd1234};
        wait_valid(40, w);
        expect_disp("v1234", 16'h1234, 1'b0);
        wait_valid(40, w);
        total++;
        assert (w == 18) else begin bad++; $error("FAIL period obs=%0d exp=18", w); end

        // Saturation and boundary values.
        src_value[15:0] = 16'hFFFF;
        wait_valid(40, w);
        expect_disp("vffff", 16'h9999, 1'b1);
        src_value[15:0] = 16'd9999;
        wait_valid(40, w);
        expect_disp("v9999", 16'h9999, 1'b0);
        src_value[15:0] = 16'd0;
        wait_valid(40, w);
        expect_disp("v0", 16'h0000, 1'b0);

        // Holder drops at dwell 3 while source 1 requests.
        do_reset(2);
        src_req = 3'b011;
        for (int i = 0; i < 4; i++) tick();
        expect_grant("pre_drop", 3'b001);
        src_req = 3'b010;
        tick();
        expect_grant("drop_pass", 3'b010);
        src_req = 3'b001;
        for (int i = 0; i < 30; i++) tick();
        expect_grant("sole_keep", 3'b001);

        // Grant rotates during SHIFT; in-flight value completes unaffected.
        do_reset(2);
        src_req = 3'b001;
        src_value = {16'd0, 16'd7, 16'd42};
        tick();
        for (int i = 0; i < 6; i++) tick();
        src_req = 3'b010;
        src_value[15:0] = 16'd5555;
        wait_valid(40, w);
        expect_disp("inflight42", 16'h0042, 1'b0);
        wait_valid(40, w);
        expect_disp("next7", 16'h0007, 1'b0);

        // Reset during SHIFT iteration 10, then fresh conversion.
        do_reset(2);
        src_req = 3'b001;
        src_value = {16'd0, 16'd0, 16'd5678};
        for (int i = 0; i < 40 && !(m_busy && m_cnt == 10); i++) tick();
        do_reset(3);
        expect_disp("mid_reset", 16'h0000, 1'b0);
        wait_valid(40, w);
        expect_disp("after_reset", 16'h5678, 1'b0);

        // Random requests and values against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) src_req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) src_value = {16'($urandom), 16'($urandom_range(0, 12000)), 16'($urandom_range(0, 9999))};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL take parameter HOLD_CYCLES, default 100000000, the minimum grant dwell in clk cycles (>=1; 1 s at 100 MHz).
REQ-002 The block SHALL take parameter SAT_MAX, default 9999, the largest value shown on the 4-digit display.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port src_req, input, 3, per-source request for the display (bit i = source i).
REQ-006 The block SHALL have port src_value, input, 48, packed binary values; source i at [16*i+15:16*i].
REQ-007 The block SHALL have port src_grant, output, 3, one-hot or zero display ownership.
REQ-008 The block SHALL have port disp_bcd, output, 16, packed BCD digits; thousands at [15:12], units at [3:0].
REQ-009 The block SHALL have port disp_valid, output, 1, one-cycle pulse when disp_bcd updates.
REQ-010 The block SHALL have port disp_ovf, output, 1, high when the displayed sample exceeded SAT_MAX.

Function
REQ-011 Arbitration SHALL be registered round-robin: with src_grant==0 and any src_req high at edge E, src_grant SHALL become one-hot at E.
REQ-012 Search order SHALL start at the source after the last holder and wrap (2->0); after reset the last holder SHALL be 2, so source 0 has first priority.
REQ-013 A 32-bit hold counter SHALL clear on every new grant and increment each cycle the grant is unchanged, saturating at HOLD_CYCLES.
REQ-014 When the holder's src_req drops, the grant SHALL pass at the next edge to the next requester in order, excluding the holder, or to 0 if there is none; this takes effect regardless of the hold count.
REQ-015 When the hold count reaches HOLD_CYCLES and another source requests, the grant SHALL rotate directly to it at the next edge with no zero-grant gap.
REQ-016 When the hold count reaches HOLD_CYCLES and no other source requests, the holder SHALL keep the grant and the counter SHALL clear.
REQ-017 If hold expiry and the holder's request drop coincide, REQ-014 SHALL govern.
REQ-018 The converter FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-019 IDLE->SHIFT: at an edge with src_grant!=0, the FSM SHALL capture the granted source's value, saturated to SAT_MAX, and latch an ovf flag (value>SAT_MAX).
REQ-020 SHIFT SHALL perform 16 double-dabble iterations, one per edge: add 3 to any BCD nibble >=5, then shift left one bit. The 16th iteration SHALL move the FSM to DONE.
REQ-021 DONE SHALL load disp_bcd and disp_ovf, pulse disp_valid for one cycle, and return to IDLE.
REQ-022 Latency SHALL be fixed: capture at edge E0, outputs and disp_valid visible after edge E0+17; the next capture is at E0+18 at the earliest.
REQ-023 Grant changes during SHIFT/DONE SHALL NOT abort a conversion; the in-flight value completes and the next capture uses the current holder.
REQ-024 With src_grant==0 the FSM SHALL stay in IDLE and disp_bcd/disp_ovf SHALL hold their last values.
REQ-025 src_value SHALL be sampled only at the capture edge; changes at other times SHALL have no effect on the conversion in flight.

Reset
REQ-026 While reset is low, outputs SHALL be: src_grant=0, disp_bcd=16'h0000, disp_valid=0, disp_ovf=0. Internal state SHALL be: FSM=IDLE, hold counter=0, last holder=2.
REQ-027 Reset asserted mid-conversion SHALL discard the conversion immediately, with no disp_valid pulse.
REQ-028 After reset release, the first grant SHALL occur no earlier than the first rising edge with reset high.

Verification (HOLD_CYCLES=8)
REQ-029 src_req=3'b111 from reset release -> grant 001; grant 010 after 8 dwell cycles, then 100, then 001.
REQ-030 Source 0 only, value 1234 -> disp_bcd=16'h1234, disp_ovf=0, disp_valid pulse 17 edges after capture, then repeating every 18 cycles.
REQ-031 Granted value 16'hFFFF -> disp_bcd=16'h9999, disp_ovf=1; value 9999 -> 16'h9999, disp_ovf=0; value 0 -> 16'h0000.
REQ-032 Holder 0 drops req at dwell cycle 3 while req1 high -> grant 010 at the next edge; req0 alone at expiry -> grant stays 001.
REQ-033 Grant rotates 0->1 at SHIFT iteration 5 (values 42 and 7) -> first disp_bcd=16'h0042, next=16'h0007.
REQ-034 reset pulled low at SHIFT iteration 10 -> all outputs zero, no disp_valid; after release a fresh conversion completes correctly.
